// File: rtl/ob_host_if.sv
// Order-book command/response link: the host drives commands and response-accept,
// the order book drives backpressure and responses.
interface ob_host_if #(
  parameter int unsigned CMD_W = 64,
  parameter int unsigned RSP_W = 64
);
  logic             cmd_vld_r;
  logic [CMD_W-1:0] cmd_r;
  logic             cmd_full_r;
  logic             rsp_vld;
  logic [RSP_W-1:0] rsp;
  logic             rsp_accept;

  modport master (
    output cmd_vld_r, cmd_r, rsp_accept,
    input  cmd_full_r, rsp_vld, rsp
  );

  modport slave (
    input  cmd_vld_r, cmd_r, rsp_accept,
    output cmd_full_r, rsp_vld, rsp
  );
endinterface

// File: rtl/ob_host.sv
// Order-book host initiator: command queue, response queue, in-flight tracking, flush/drain FSM.
// Optional: define OB_HOST_STATS_EN to add issue/accept event counters.
module ob_host #(
  parameter int unsigned CMD_W        = 64,
  parameter int unsigned RSP_W        = 64,
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned RSP_DEPTH    = 4,
  parameter int unsigned MAX_INFLIGHT = 8,
  localparam int unsigned IF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [CMD_W-1:0] in_cmd,
  output logic             in_rdy,
  ob_host_if.master        ob,
  output logic             out_vld,
  output logic [RSP_W-1:0] out_rsp,
  input  logic             out_accept,
  input  logic             flush,
  output logic             idle,
  output logic [IF_W-1:0]  in_flight
`ifdef OB_HOST_STATS_EN
  ,
  output logic [31:0]      stat_cmd_issued,
  output logic [31:0]      stat_rsp_accepted
`endif
);

  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned RAW = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_e;

  state_e state, state_nxt;

  // Command queue: pointers carry an extra wrap bit to tell full from empty
  logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
  logic [CAW:0]     cmd_wr, cmd_rd;
  logic             cmd_empty, cmd_full, push, issue;

  assign cmd_empty = (cmd_wr == cmd_rd);
  assign cmd_full  = (cmd_wr[CAW] != cmd_rd[CAW]) && (cmd_wr[CAW-1:0] == cmd_rd[CAW-1:0]);
  assign push      = in_vld & in_rdy;
  assign issue     = !cmd_empty && !ob.cmd_full_r && (in_flight < IF_W'(MAX_INFLIGHT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wr <= '0;
      cmd_rd <= '0;
    end else begin
      if (push)  cmd_wr <= cmd_wr + 1'b1;
      if (issue) cmd_rd <= cmd_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) cmd_mem[cmd_wr[CAW-1:0]] <= in_cmd;
  end

  // Registered issue: the popped head appears on cmd_r one cycle after the pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob.cmd_vld_r <= 1'b0;
      ob.cmd_r     <= '0;
    end else begin
      ob.cmd_vld_r <= issue;
      if (issue) ob.cmd_r <= cmd_mem[cmd_rd[CAW-1:0]];
    end
  end

  // Response queue
  logic [RSP_W-1:0] rsp_mem [RSP_DEPTH];
  logic [RAW:0]     rsp_wr, rsp_rd;
  logic             rsp_empty, rsp_full, rsp_pop;

  assign rsp_empty     = (rsp_wr == rsp_rd);
  assign rsp_full      = (rsp_wr[RAW] != rsp_rd[RAW]) && (rsp_wr[RAW-1:0] == rsp_rd[RAW-1:0]);
  assign ob.rsp_accept = ob.rsp_vld & !rsp_full;
  assign out_vld       = !rsp_empty;
  assign out_rsp       = rsp_mem[rsp_rd[RAW-1:0]];
  assign rsp_pop       = out_vld & out_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_wr <= '0;
      rsp_rd <= '0;
    end else begin
      if (ob.rsp_accept) rsp_wr <= rsp_wr + 1'b1;
      if (rsp_pop)       rsp_rd <= rsp_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ob.rsp_accept) rsp_mem[rsp_wr[RAW-1:0]] <= ob.rsp;
  end

  // In-flight count; a stray response with nothing outstanding leaves it at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight <= '0;
    end else if (issue && !ob.rsp_accept) begin
      in_flight <= in_flight + 1'b1;
    end else if (!issue && ob.rsp_accept && (in_flight != '0)) begin
      in_flight <= in_flight - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    unique case (state)
      RUN: begin
        in_rdy = !cmd_full;
        if (flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cmd_empty && (in_flight == '0)) state_nxt = IDLE;
      end
      IDLE: begin
        if (!flush) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle <= 1'b0;
    else      idle <= (state == IDLE);
  end

`ifdef OB_HOST_STATS_EN
  logic enter_idle;
  assign enter_idle = (state_nxt == IDLE) && (state != IDLE);

  // Event counters, zeroed as the block settles into IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cmd_issued   <= '0;
      stat_rsp_accepted <= '0;
    end else if (enter_idle) begin
      stat_cmd_issued   <= '0;
      stat_rsp_accepted <= '0;
    end else begin
      if (issue)         stat_cmd_issued   <= stat_cmd_issued + 32'd1;
      if (ob.rsp_accept) stat_rsp_accepted <= stat_rsp_accepted + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
                                    !(ob.rsp_accept && (in_flight == '0)))
    else $error("ob_host: response accepted with no command in flight");
`endif

endmodule

// File: tb/tb_ob_host.sv
// Directed bench for ob_host: a queue-level reference model compared every cycle,
// plus hand-computed literal checks around each scenario.
`timescale 1ns/1ps
module tb_ob_host;
  localparam int unsigned CMD_W = 64;
  localparam int unsigned RSP_W = 64;
  localparam int unsigned IF_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_vld, in_rdy, out_vld, out_accept, flush, idle;
  logic [CMD_W-1:0] in_cmd;
  logic [RSP_W-1:0] out_rsp;
  logic [IF_W-1:0]  in_flight;
`ifdef OB_HOST_STATS_EN
  logic [31:0]      stat_cmd_issued, stat_rsp_accepted;
`endif

  ob_host_if #(.CMD_W(CMD_W), .RSP_W(RSP_W)) bus ();

  ob_host #(.CMD_W(CMD_W), .RSP_W(RSP_W), .CMD_DEPTH(4), .RSP_DEPTH(4), .MAX_INFLIGHT(8)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_cmd(in_cmd), .in_rdy(in_rdy), .ob(bus),
    .out_vld(out_vld), .out_rsp(out_rsp), .out_accept(out_accept),
    .flush(flush), .idle(idle), .in_flight(in_flight)
`ifdef OB_HOST_STATS_EN
    , .stat_cmd_issued(stat_cmd_issued), .stat_rsp_accepted(stat_rsp_accepted)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queues and counts, advanced once per clock
  logic [CMD_W-1:0] mq_cmd[$];
  logic [RSP_W-1:0] mq_rsp[$];
  bit               m_vld, m_idle;
  logic [CMD_W-1:0] m_cmd;
  int               m_inflight, m_mode, nmode;
  bit               e_rdy, e_acc, e_outv, m_iss, m_psh, m_pop;
  logic [31:0]      m_si, m_sa;

  always @(negedge clk) begin
    if (!rst) begin
      mq_cmd.delete(); mq_rsp.delete();
      m_vld = 0; m_cmd = '0; m_inflight = 0; m_mode = 0; m_idle = 0; m_si = '0; m_sa = '0;
    end
    e_rdy  = (m_mode == 0) && (mq_cmd.size() < 4);
    e_acc  = bus.rsp_vld && (mq_rsp.size() < 4);
    e_outv = (mq_rsp.size() > 0);
    chk("cmd_vld_r",  64'(bus.cmd_vld_r),  64'(m_vld));
    chk("cmd_r",      bus.cmd_r,           m_cmd);
    chk("in_rdy",     64'(in_rdy),         64'(e_rdy));
    chk("rsp_accept", 64'(bus.rsp_accept), 64'(e_acc));
    chk("out_vld",    64'(out_vld),        64'(e_outv));
    if (e_outv) chk("out_rsp", out_rsp, mq_rsp[0]);
    chk("in_flight",  64'(in_flight),      64'(m_inflight));
    chk("idle",       64'(idle),           64'(m_idle));
`ifdef OB_HOST_STATS_EN
    chk("stat_cmd_issued",   64'(stat_cmd_issued),   64'(m_si));
    chk("stat_rsp_accepted", 64'(stat_rsp_accepted), 64'(m_sa));
`endif
    if (rst) begin
      m_psh = in_vld && e_rdy;
      m_iss = (mq_cmd.size() > 0) && !bus.cmd_full_r && (m_inflight < 8);
      m_pop = e_outv && out_accept;
      nmode = m_mode;
      case (m_mode)
        0:       if (flush) nmode = 1;
        1:       if (mq_cmd.size() == 0 && m_inflight == 0) nmode = 2;
        default: if (!flush) nmode = 0;
      endcase
      m_idle = (m_mode == 2);
      m_vld  = m_iss;
      if (m_iss) m_cmd = mq_cmd.pop_front();
      if (m_psh) mq_cmd.push_back(in_cmd);
      if (m_iss && !e_acc) m_inflight++;
      else if (!m_iss && e_acc && m_inflight > 0) m_inflight--;
      if (m_pop) void'(mq_rsp.pop_front());
      if (e_acc) mq_rsp.push_back(bus.rsp);
      if (m_mode != 2 && nmode == 2) begin
        m_si = '0; m_sa = '0;
      end else begin
        if (m_iss) m_si = m_si + 32'd1;
        if (e_acc) m_sa = m_sa + 32'd1;
      end
      m_mode = nmode;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic [CMD_W-1:0] v);
    int n = 0;
    in_vld = 1'b1; in_cmd = v;
    while (!in_rdy && n < 50) begin step(); n++; end
    chk("push_wait_in_rdy", 64'(in_rdy), 64'd1);
    step();
    in_vld = 1'b0;
  endtask

  task automatic send_rsp(input logic [RSP_W-1:0] v);
    int n = 0;
    bus.rsp_vld = 1'b1; bus.rsp = v; #1;
    while (!bus.rsp_accept && n < 50) begin step(); n++; end
    chk("rsp_wait_accept", 64'(bus.rsp_accept), 64'd1);
    step();
    bus.rsp_vld = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    in_vld = 0; in_cmd = '0; out_accept = 1; flush = 0;
    bus.cmd_full_r = 0; bus.rsp_vld = 0; bus.rsp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_vld", 64'(bus.cmd_vld_r), 64'd0);
    chk("rst_in_rdy",  64'(in_rdy),        64'd1);
    chk("rst_idle",    64'(idle),          64'd0);
    chk("rst_out_vld", 64'(out_vld),       64'd0);
    rst = 1'b1;
    step();

    // Three back-to-back pushes: first command visible two cycles after in_vld rises
    in_vld = 1; in_cmd = 64'h11; step();
    chk("t1_no_vld_yet", 64'(bus.cmd_vld_r), 64'd0);
    in_cmd = 64'h22; step();
    chk("t1_vld0", 64'(bus.cmd_vld_r), 64'd1);
    chk("t1_cmd0", bus.cmd_r, 64'h11);
    in_cmd = 64'h33; step();
    chk("t1_cmd1", bus.cmd_r, 64'h22);
    in_vld = 0; step();
    chk("t1_cmd2", bus.cmd_r, 64'h33);
    step();
    chk("t1_vld_end", 64'(bus.cmd_vld_r), 64'd0);
    chk("t1_hold",    bus.cmd_r,          64'h33);
    chk("t1_inflight", 64'(in_flight),    64'd3);
    for (int i = 0; i < 3; i++) send_rsp(64'hA0 + 64'(i));
    chk("t1_inflight0", 64'(in_flight), 64'd0);

    // Backpressure fills the queue; release lets the fifth in
    bus.cmd_full_r = 1;
    for (int i = 0; i < 4; i++) push_cmd(64'h200 + 64'(i));
    chk("t2_rdy_full", 64'(in_rdy),        64'd0);
    chk("t2_no_issue", 64'(bus.cmd_vld_r), 64'd0);
    bus.cmd_full_r = 0;
    push_cmd(64'h204);
    repeat (4) step();
    chk("t2_inflight5", 64'(in_flight), 64'd5);
    for (int i = 0; i < 5; i++) send_rsp(64'hB00 + 64'(i));

    // In-flight limit holds the ninth command until a response frees a slot
    for (int i = 0; i < 9; i++) push_cmd(64'h300 + 64'(i));
    repeat (4) step();
    chk("t3_inflight8", 64'(in_flight),    64'd8);
    chk("t3_held",      64'(bus.cmd_vld_r), 64'd0);
    bus.rsp_vld = 1; bus.rsp = 64'hC00; #1;
    chk("t3_acc", 64'(bus.rsp_accept), 64'd1);
    step();
    bus.rsp_vld = 0;
    chk("t3_inflight7", 64'(in_flight),     64'd7);
    chk("t3_not_yet",   64'(bus.cmd_vld_r), 64'd0);
    step();
    chk("t3_ninth_vld", 64'(bus.cmd_vld_r), 64'd1);
    chk("t3_ninth_cmd", bus.cmd_r,          64'h308);
    for (int i = 0; i < 8; i++) send_rsp(64'hC01 + 64'(i));
    repeat (2) step();

    // Response queue full with downstream stalled
    for (int i = 0; i < 5; i++) push_cmd(64'h400 + 64'(i));
    repeat (4) step();
    chk("t4_inflight5", 64'(in_flight), 64'd5);
    out_accept = 0;
    bus.rsp_vld = 1;
    for (int i = 0; i < 4; i++) begin
      bus.rsp = 64'hD0 + 64'(i); #1;
      chk("t4_acc", 64'(bus.rsp_accept), 64'd1);
      step();
    end
    bus.rsp = 64'hD4; #1;
    chk("t4_blocked",  64'(bus.rsp_accept), 64'd0);
    chk("t4_head",     out_rsp,             64'hD0);
    step();
    out_accept = 1; #1;
    chk("t4_gated_by_full", 64'(bus.rsp_accept), 64'd0);
    step();
    out_accept = 0; #1;
    chk("t4_fifth_acc", 64'(bus.rsp_accept), 64'd1);
    chk("t4_head1",     out_rsp,             64'hD1);
    step();
    bus.rsp_vld = 0; out_accept = 1;
    n = 0;
    while (out_vld && n < 20) begin step(); n++; end
    chk("t4_drained",   64'(out_vld),   64'd0);
    chk("t4_inflight0", 64'(in_flight), 64'd0);

    // Flush with two queued and one outstanding
    push_cmd(64'h500);
    repeat (2) step();
    chk("t5_inflight1", 64'(in_flight), 64'd1);
    bus.cmd_full_r = 1;
    push_cmd(64'h501); push_cmd(64'h502);
    flush = 1; bus.cmd_full_r = 0; step();
    chk("t5_rdy_drain", 64'(in_rdy), 64'd0);
    repeat (3) step();
    chk("t5_inflight3", 64'(in_flight), 64'd3);
    for (int i = 0; i < 3; i++) send_rsp(64'hE0 + 64'(i));
    n = 0;
    while (!idle && n < 20) begin step(); n++; end
    chk("t5_idle",      64'(idle),      64'd1);
    chk("t5_inflight0", 64'(in_flight), 64'd0);
    flush = 0; step();
    chk("t5_rdy_back", 64'(in_rdy), 64'd1);
    repeat (2) step();
    // Short flush pulse with nothing pending: drains through IDLE and returns
    flush = 1; step(); flush = 0;
    repeat (5) step();
    chk("t5_pulse_rdy", 64'(in_rdy), 64'd1);

    // Asynchronous reset mid-operation
    bus.cmd_full_r = 1;
    for (int i = 0; i < 4; i++) push_cmd(64'h600 + 64'(i));
    bus.cmd_full_r = 0; step();
    chk("t6_vld_before", 64'(bus.cmd_vld_r), 64'd1);
    #1 rst = 1'b0; #1;
    chk("t6_vld",      64'(bus.cmd_vld_r), 64'd0);
    chk("t6_cmd",      bus.cmd_r,          64'd0);
    chk("t6_inflight", 64'(in_flight),     64'd0);
    chk("t6_in_rdy",   64'(in_rdy),        64'd1);
    chk("t6_out_vld",  64'(out_vld),       64'd0);
    chk("t6_idle",     64'(idle),          64'd0);
    step(); step();
    rst = 1'b1;
    repeat (6) step();
    chk("t6_no_issue", 64'(bus.cmd_vld_r), 64'd0);
    chk("t6_empty",    64'(in_flight),     64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
